// File: rtl/seq_detector_param.sv
//------------------------------------------------------------------------------
// seq_detector_param : run-time programmable Mealy serial-pattern detector
//                      with selectable overlap mode and saturating match count.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module seq_detector_param #(
  parameter int unsigned    N           = 4,
  parameter logic [N-1:0]   PATTERN_RST = 4'b1010,
  parameter int unsigned    CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             overlap,
  input  logic [N-1:0]     cfg_pattern,
  input  logic             cfg_load,
  input  logic             cnt_clr,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic [N-1:0]     cur_pat
);

  localparam int unsigned          FILL_W    = $clog2(N);
  localparam logic [FILL_W-1:0]    FILL_FULL = FILL_W'(N - 1);
  localparam logic [CNT_W-1:0]     CNT_MAX   = '1;

  logic [N-2:0]      hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [N-1:0]      pat_q,  pat_d;
  logic [CNT_W-1:0]  cnt_q,  cnt_d;

  logic [N-2:0]      hist_shift;
  logic [FILL_W-1:0] fill_inc;
  logic              hist_full;

  // A two-bit pattern keeps only one history bit, so there is nothing to shift up.
  generate
    if (N == 2) begin : g_hist_n2
      assign hist_shift = din;
    end else begin : g_hist_wide
      assign hist_shift = {hist_q[N-3:0], din};
    end
  endgenerate

  assign hist_full = (fill_q == FILL_FULL);
  assign fill_inc  = hist_full ? FILL_FULL : fill_q + FILL_W'(1);

  assign match = din_valid & ~cfg_load & hist_full & ({hist_q, din} == pat_q);

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    pat_d  = pat_q;
    if (cfg_load) begin
      pat_d  = cfg_pattern;
      fill_d = '0;
    end else if (din_valid) begin
      hist_d = hist_shift;
      // Non-overlapping: history contents stay but are ignored until refilled.
      if (match && !overlap) begin
        fill_d = '0;
      end else begin
        fill_d = fill_inc;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (match && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q <= '0;
      fill_q <= '0;
      pat_q  <= PATTERN_RST;
      cnt_q  <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      pat_q  <= pat_d;
      cnt_q  <= cnt_d;
    end
  end

  assign match_cnt = cnt_q;
  assign cur_pat   = pat_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_detector_param.sv
//------------------------------------------------------------------------------
// tb_seq_detector_param : scoreboard bench for seq_detector_param (N=4), with a
//                         CNT_W=8 and a CNT_W=2 instance driven in parallel.
//------------------------------------------------------------------------------
`default_nettype none

module tb_seq_detector_param;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic din = 1'b0, din_valid = 1'b0, overlap = 1'b0;
  logic [N-1:0] cfg_pattern = '0;
  logic cfg_load = 1'b0, cnt_clr = 1'b0;

  logic       match8, match2;
  logic [7:0] cnt8;
  logic [1:0] cnt2;
  logic [N-1:0] pat8, pat2;

  seq_detector_param #(.N(4), .PATTERN_RST(4'b1010), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .overlap(overlap),
    .cfg_pattern(cfg_pattern), .cfg_load(cfg_load), .cnt_clr(cnt_clr),
    .match(match8), .match_cnt(cnt8), .cur_pat(pat8));

  seq_detector_param #(.N(4), .PATTERN_RST(4'b1010), .CNT_W(2)) dut_w2 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .overlap(overlap),
    .cfg_pattern(cfg_pattern), .cfg_load(cfg_load), .cnt_clr(cnt_clr),
    .match(match2), .match_cnt(cnt2), .cur_pat(pat2));

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: accepted bits since the last flush, oldest first.
  bit         hq[$];
  logic [3:0] m_pat = 4'b1010;
  int         m_c8 = 0;
  int         m_c2 = 0;

  typedef struct { logic [7:0] c8; logic [1:0] c2; logic [3:0] pat; } regs_t;
  logic  exp_match_q[$];
  regs_t exp_regs_q[$];

  logic [31:0] mhist = '0;   // observed match per step, newest in bit 0

  function automatic logic model_match(input logic v, input logic d, input logic ld);
    if (ld || !v || hq.size() != N - 1) return 1'b0;
    return ({hq[0], hq[1], hq[2], d} == m_pat);
  endfunction

  task automatic model_reset();
    hq.delete();
    m_pat = 4'b1010;
    m_c8  = 0;
    m_c2  = 0;
    exp_match_q.delete();
    exp_regs_q.delete();
  endtask

  task automatic step(input logic v, input logic d, input logic ld = 1'b0,
                      input logic [3:0] cp = 4'b0000, input logic clr = 1'b0);
    logic  em;
    logic  e;
    regs_t r;
    @(negedge clk);
    din_valid = v; din = d; cfg_load = ld; cfg_pattern = cp; cnt_clr = clr;
    em = model_match(v, d, ld);
    exp_match_q.push_back(em);
    #1;
    e = exp_match_q.pop_front();
    check("match", {31'b0, match8}, {31'b0, e});
    check("match_w2", {31'b0, match2}, {31'b0, e});
    mhist = {mhist[30:0], match8};
    if (ld) begin
      m_pat = cp;
      hq.delete();
    end else if (v) begin
      if (em && !overlap) hq.delete();
      else begin
        hq.push_back(d);
        if (hq.size() > N - 1) void'(hq.pop_front());
      end
    end
    if (clr) begin
      m_c8 = 0; m_c2 = 0;
    end else if (em) begin
      if (m_c8 < 255) m_c8++;
      if (m_c2 < 3)   m_c2++;
    end
    exp_regs_q.push_back('{c8: 8'(m_c8), c2: 2'(m_c2), pat: m_pat});
    @(posedge clk);
    #1;
    r = exp_regs_q.pop_front();
    check("match_cnt", {24'b0, cnt8}, {24'b0, r.c8});
    check("match_cnt_w2", {30'b0, cnt2}, {30'b0, r.c2});
    check("cur_pat", {28'b0, pat8}, {28'b0, r.pat});
  endtask

  // Holds reset low across one rising edge and checks the asynchronous values.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    din_valid = 1'b1; din = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
    #1;
    model_reset();
    check("rst_match", {31'b0, match8}, 32'd0);
    check("rst_cnt", {24'b0, cnt8}, 32'd0);
    check("rst_cnt_w2", {30'b0, cnt2}, 32'd0);
    check("rst_pat", {28'b0, pat8}, 32'hA);
    @(negedge clk);
    din_valid = 1'b0;
    rst = 1'b1;
  endtask

  task automatic fresh(input logic [3:0] p);
    step(1'b0, 1'b0, 1'b1, p, 1'b1);
    mhist = '0;
  endtask

  initial begin
    do_reset();

    // Non-overlapping 1010 twice
    overlap = 1'b0;
    for (int i = 0; i < 8; i++) step(1'b1, (i % 2 == 0));
    check("nonov_pos", mhist & 32'hFF, 32'b0001_0001);
    check("nonov_cnt", {24'b0, cnt8}, 32'd2);

    // Overlapping vs non-overlapping on 1010101
    fresh(4'b1010);
    overlap = 1'b1;
    for (int i = 0; i < 7; i++) step(1'b1, (i % 2 == 0));
    check("ov_pos", mhist & 32'h7F, 32'b000_1010);
    check("ov_cnt", {24'b0, cnt8}, 32'd2);
    fresh(4'b1010);
    overlap = 1'b0;
    for (int i = 0; i < 7; i++) step(1'b1, (i % 2 == 0));
    check("nonov7_pos", mhist & 32'h7F, 32'b000_1000);
    check("nonov7_cnt", {24'b0, cnt8}, 32'd1);

    // Valid gaps with random din in the gaps
    fresh(4'b1010);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, (i % 2 == 0));
      if (i < 3) for (int g = 0; g < 3; g++) step(1'b0, 1'($urandom_range(0, 1)));
    end
    check("gap_pos", mhist & 32'h1FFF, 32'd1);
    check("gap_cnt", {24'b0, cnt8}, 32'd1);

    // Reset in the middle of a pattern
    fresh(4'b1010);
    step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b1);
    do_reset();
    mhist = '0;
    step(1'b1, 1'b0);
    step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b1); step(1'b1, 1'b0);
    check("rstmid_pos", mhist & 32'h1F, 32'b0_0001);
    check("rstmid_cnt", {24'b0, cnt8}, 32'd1);

    // Reconfiguration with a colliding valid bit
    fresh(4'b1010);
    step(1'b1, 1'b1); step(1'b1, 1'b1); step(1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 4'b1100);
    check("cfg_pat", {28'b0, pat8}, 32'hC);
    check("cfg_drop", {31'b0, mhist[0]}, 32'd0);
    step(1'b1, 1'b1); step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b0);
    check("cfg_pos", mhist & 32'hF, 32'b0001);

    // Saturation at CNT_W=2 and clear in a match cycle
    fresh(4'b1111);
    overlap = 1'b1;
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1);
    check("sat_pos", mhist & 32'h7F, 32'b000_1111);
    check("sat_cnt_w2", {30'b0, cnt2}, 32'd3);
    check("sat_cnt", {24'b0, cnt8}, 32'd4);
    step(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1);
    check("clr_match", {31'b0, mhist[0]}, 32'd1);
    check("clr_cnt_w2", {30'b0, cnt2}, 32'd0);
    check("clr_cnt", {24'b0, cnt8}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised Mealy serial-pattern detector: the next generation of the team's fixed non-overlapping `1010` detector. It sits on a one-bit serial stream with a valid qualifier and flags each occurrence of a run-time programmable pattern of `N` bits. The overlap mode is selectable at run time, and a saturating counter keeps a running total of matches.

## Interface
- `N`, default 4: pattern length in bits; legal range 2..16.
- `PATTERN_RST`, default 4'b1010: pattern in effect after reset. It is `N` bits wide, and its MSB is compared against the oldest bit.
- `CNT_W`, default 8: width of the match counter.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst`  in  1: reset, asynchronous, active-low.
- `din`  in  1: serial data bit.
- `din_valid`  in  1: `din` is consumed on a rising edge only when this is 1.
- `overlap`  in  1: 1 selects overlapping detection; 0 selects non-overlapping detection.
- `cfg_pattern`  in  N: new pattern value.
- `cfg_load`  in  1: on a rising edge, loads `cfg_pattern` and clears the history.
- `cnt_clr`  in  1: synchronous clear of `match_cnt`.
- `match`  out  1: Mealy output, combinational.
- `match_cnt`  out  CNT_W: registered count of matches, saturating.
- `cur_pat`  out  N: pattern currently in effect (registered).

## Operation
- **Internal state**
  - `hist`: N-1 bit shift register holding the most recent accepted bits.
  - `fill`: count of valid history bits, range 0..N-1.
  - `pat`: the active pattern.
- **match**
  - `match = din_valid & ~cfg_load & (fill == N-1) & ({hist, din} == pat)`.
  - It is purely combinational and asserts in the same cycle as the final pattern bit.
- **Accepted bit, no match** (`din_valid=1`, `cfg_load=0`, `match=0`)
  - `hist <= {hist[N-3:0], din}`.
  - `fill <= min(fill+1, N-1)`.
- **Accepted bit, match**
  - Overlapping mode (`overlap=1`): shift exactly as in the no-match case. `fill` stays at N-1.
  - Non-overlapping mode (`overlap=0`): `fill <= 0`. The history contents become don't-care, and the next match needs N fresh bits.
- **Idle** (`din_valid=0`): `hist`, `fill` and `match` are unaffected, so gaps in valid are transparent.
- **Pattern load** (`cfg_load=1`)
  - `pat <= cfg_pattern` and `fill <= 0`.
  - If `din_valid` is also 1, the bit is discarded and `match=0`.
- **Counter**
  - On a rising edge with `match=1`: `match_cnt <= match_cnt + 1`, saturating at 2^CNT_W-1 with no wrap.
  - `cnt_clr=1` sets `match_cnt` to 0 and has priority over a simultaneous increment. `match` itself is still reported in that cycle.
- **Mode change**: `overlap` is sampled every cycle and affects only the cycle in which a match occurs. No history flush occurs on a mode change.

## Timing
- **Reset values** (while `rst=0`, asynchronously)
  - `fill=0`, `hist=0`, `pat=PATTERN_RST`.
  - `match_cnt=0`, `cur_pat=PATTERN_RST`.
  - `match=0`, because `fill != N-1`.
- **Release**: the first rising edge after `rst` deasserts may accept a bit.
- **Latency**
  - `match`: 0 cycles from the final pattern bit, valid before the edge that consumes that bit.
  - `match_cnt`: updates 1 cycle after `match`.
  - `cur_pat`: updates 1 cycle after `cfg_load`.
- **Reset mid-pattern**: partial history is lost, and no match is possible until N new bits have been accepted.
- **Match rate**
  - Non-overlapping: at most one match per N accepted bits.
  - Overlapping: a pattern whose own suffix equals its prefix can match more often, e.g. `1111` matches on every bit once `fill=N-1`.
- **Input timing**: `din` and `din_valid` must be stable around the edge. `match` may glitch combinationally between edges and must be sampled only at the edge.

## Test plan
Defaults apply unless stated: N=4, pattern `1010`, CNT_W=8.
- **Non-overlapping**: `overlap=0`; bits 1,0,1,0,1,0,1,0 on consecutive valid cycles -> `match=1` on bits 4 and 8 only; `match_cnt=2`.
- **Overlapping**: `overlap=1`; bits 1,0,1,0,1,0,1 -> `match=1` on bits 4 and 6; the same stream with `overlap=0` -> match on bit 4 only; `match_cnt` 2 vs 1.
- **Valid gaps**: bits 1,0,1,0 with `din_valid=0` for 3 cycles between each bit, and `din` toggling randomly during the gaps -> a single match on the 4th valid bit; `match=0` in every gap cycle.
- **Reset mid-pattern**: 1,0,1, then `rst=0` for 1 cycle, then 0 -> no match. Then 1,0,1,0 -> match on the last bit. `match_cnt`=0 immediately after reset.
- **Reconfiguration**: accept 1,1,1, then `cfg_load` with `cfg_pattern=1100` in the same cycle as `din=1, din_valid=1`. Required response:
  - That bit is discarded, `match=0`, and `cur_pat=1100` on the next cycle.
  - Then 1,1,0,0 -> match on the 4th bit.
- **Counter saturation and clear**: CNT_W=2, `overlap=1`, pattern `1111`, seven 1s -> matches on bits 4..7 and `match_cnt` saturates at 3 (not 0). `cnt_clr` asserted in a match cycle -> `match_cnt=0` next cycle while `match=1` is still seen.
